// File: rtl/vdp_reg_write_sink_if.sv
// Register-write bus between the copper/host sources, the write sink and the VDP register file.
interface vdp_reg_write_sink_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [5:0]    copper_write_address;
    logic [15:0]   copper_write_data;
    logic          copper_write_en;
    logic          copper_write_ready;
    logic [5:0]    host_write_address;
    logic [15:0]   host_write_data;
    logic          host_write_en;
    logic          host_write_ready;
    logic          commit_stall;
    logic [5:0]    commit_address;
    logic [15:0]   commit_data;
    logic          commit_en;
    logic          commit_source;
    logic [LW-1:0] fifo_level;

    modport master (
        output copper_write_address, copper_write_data, copper_write_en,
        output host_write_address, host_write_data, host_write_en,
        output commit_stall,
        input  copper_write_ready, host_write_ready,
        input  commit_address, commit_data, commit_en, commit_source, fifo_level
    );

    modport slave (
        input  copper_write_address, copper_write_data, copper_write_en,
        input  host_write_address, host_write_data, host_write_en,
        input  commit_stall,
        output copper_write_ready, host_write_ready,
        output commit_address, commit_data, commit_en, commit_source, fifo_level
    );
endinterface

// File: rtl/vdp_reg_write_sink.sv
// VDP register-write sink: copper FIFO + host holding register, arbitrated into one commit per cycle.
// Optional copper stall statistics counter enabled by VDP_REG_WRITE_SINK_STATS_EN.
module vdp_reg_write_sink #(
    parameter int FIFO_DEPTH        = 4,
    parameter int HOST_STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    vdp_reg_write_sink_if.slave  bus
`ifdef VDP_REG_WRITE_SINK_STATS_EN
    ,
    input  logic                 stats_clear,
    output logic [15:0]          copper_stall_count
`endif
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              LW      = PW + 1;
    localparam logic [LW-1:0]   DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [7:0]      LIMIT   = 8'(HOST_STARVE_LIMIT);

    logic [21:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          host_full;
    logic [5:0]    host_addr;
    logic [15:0]   host_data;
    logic [7:0]    starve;
    logic          commit_en_q, commit_src_q;
    logic [5:0]    commit_addr_q;
    logic [15:0]   commit_data_q;
    logic          fifo_empty, push, pop, host_take, host_sel;

    // Ready flags come from registered state only, so a same-cycle pop never opens the FIFO.
    assign bus.copper_write_ready = (count != DEPTH_L);
    assign bus.host_write_ready   = !host_full;
    assign bus.fifo_level         = count;
    assign bus.commit_en          = commit_en_q;
    assign bus.commit_address     = commit_addr_q;
    assign bus.commit_data        = commit_data_q;
    assign bus.commit_source      = commit_src_q;

    always_comb begin
        fifo_empty = (count == '0);
        push       = bus.copper_write_en && bus.copper_write_ready;
        host_take  = bus.host_write_en && !host_full;
        host_sel   = 1'b0;
        pop        = 1'b0;
        if (!bus.commit_stall) begin
            host_sel = host_full && ((starve == LIMIT) || fifo_empty);
            pop      = !fifo_empty && !host_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.copper_write_address, bus.copper_write_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            host_full     <= 1'b0;
            host_addr     <= '0;
            host_data     <= '0;
            starve        <= '0;
            commit_en_q   <= 1'b0;
            commit_src_q  <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (host_take) begin
                host_full <= 1'b1;
                host_addr <= bus.host_write_address;
                host_data <= bus.host_write_data;
            end else if (host_sel) begin
                host_full <= 1'b0;
            end

            // Starvation counts copper wins only while a host write is actually waiting.
            if (!host_full || host_sel)
                starve <= '0;
            else if (pop && starve != LIMIT)
                starve <= starve + 1'b1;

            commit_en_q <= host_sel || pop;
            if (host_sel) begin
                commit_addr_q <= host_addr;
                commit_data_q <= host_data;
                commit_src_q  <= 1'b0;
            end else if (pop) begin
                commit_addr_q <= mem[rd_ptr][21:16];
                commit_data_q <= mem[rd_ptr][15:0];
                commit_src_q  <= 1'b1;
            end
        end
    end

`ifdef VDP_REG_WRITE_SINK_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stats_clear)
            stall_cnt <= '0;
        else if (bus.copper_write_en && !bus.copper_write_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign copper_stall_count = stall_cnt;
`endif
endmodule

// File: doc/vdp_reg_write_sink.md
Name: vdp_reg_write_sink

Overview:
- Receiving end of the VDP register-write interface.
- Accepts register writes from the copper (address/data/en/ready handshake) and from the host CPU bus.
- Buffers copper writes in a small FIFO, arbitrates between copper and host, and emits one committed write per cycle to the VDP register file.
- Sits between vdp_copper / host bridge and the VDP register decode.

Parameters:
- FIFO_DEPTH, 4, copper write FIFO entries; power of two, 2..16.
- HOST_STARVE_LIMIT, 8, consecutive copper commits allowed while a host write waits; 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- copper_write_address  input  6  copper target register
- copper_write_data  input  16  copper write data
- copper_write_en  input  1  copper write request
- copper_write_ready  output  1  FIFO can accept a copper write
- host_write_address  input  6  host target register
- host_write_data  input  16  host write data
- host_write_en  input  1  host write request
- host_write_ready  output  1  host holding register empty
- commit_stall  input  1  register file cannot take a write this cycle
- commit_address  output  6  committed register address
- commit_data  output  16  committed data
- commit_en  output  1  single-cycle commit strobe
- commit_source  output  1  0 = host, 1 = copper
- fifo_level  output  log2(FIFO_DEPTH)+1  copper FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, host register empty, starve counter 0. All outputs 0 except:
  - copper_write_ready = 1
  - host_write_ready = 1
  - A reset mid-operation drops all buffered and pending writes; no commit is emitted for them.
- Copper handshake:
  - A write is accepted on a rising edge where copper_write_en && copper_write_ready.
  - copper_write_ready = (fifo_level != FIFO_DEPTH), driven from registered state only; no combinational path from commit_stall or copper_write_en.
  - When full, ready = 0 even if a pop occurs the same cycle.
- Host handshake:
  - Accepted on an edge where host_write_en && host_write_ready. Address and data are latched into a one-entry holding register.
  - host_write_ready = holding register empty (registered).
- FIFO:
  - Circular buffer with pointers of log2(FIFO_DEPTH) bits that wrap naturally; separate count register.
  - Push and pop on the same edge leave the count unchanged.
  - Order is preserved strictly.
- Arbitration, evaluated each cycle when commit_stall = 0:
  - Candidates are the FIFO head (if not empty) and the host register (if full).
  - Copper wins by default.
  - Host wins if the starve counter == HOST_STARVE_LIMIT, or if the FIFO is empty.
  - Starve counter:
    - Increments on each copper commit while the host register is full, saturating at the limit.
    - Clears on a host commit, or whenever the host register is empty.
  - With commit_stall = 1: no pop, no host release, no commit; the starve counter holds.
- Commit output:
  - Registered. commit_en pulses for 1 cycle per commit, with address, data and source valid in that cycle.
  - When commit_en = 0, address/data/source hold their last values.
- Latency, idle block:
  - Copper write accepted at edge E enters the FIFO; the pop occurs at edge E+1; commit_en is high in the cycle after E+1 (2 edges).
  - Host writes have the same 2-edge latency.
  - Maximum throughput is 1 commit per cycle.
- The host register is freed on the edge it is committed, so host_write_ready rises the following cycle.

Optional Feature:
- Macro: VDP_REG_WRITE_SINK_STATS_EN.
- Defined:
  - Adds output copper_stall_count (16 bits) and input stats_clear (1 bit).
  - The counter increments each cycle with copper_write_en && !copper_write_ready and saturates at 16'hFFFF.
  - stats_clear zeroes it synchronously; clear wins over increment.
  - Reset value is 0.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Idle block, copper writes addr 0x05 data 0x1234 at edge 10 → commit_en = 1 with addr 0x05, data 0x1234, source 1 in the cycle after edge 11; fifo_level back to 0.
- commit_stall held high, copper writes 5 back-to-back → first 4 accepted, copper_write_ready = 0 after the 4th, fifo_level = 4. Release stall → 4 commits in order on consecutive cycles, ready returns high the cycle after the first pop.
- Continuous copper stream plus one host write (addr 0x20, data 0xBEEF) → exactly 8 copper commits, then the host commit (source 0), then copper resumes; no copper write lost or reordered.
- Copper and host write on the same edge into an empty block → copper commit first, host commit next cycle.
- Reset asserted asynchronously with 3 FIFO entries and a pending host write → outputs clear immediately, no commit_en after release, copper_write_ready = host_write_ready = 1.
- With VDP_REG_WRITE_SINK_STATS_EN: hold the FIFO full for 6 cycles with copper_write_en = 1 → copper_stall_count = 6; pulse stats_clear → 0.
